// File: rtl/lcd_crsr_pkg.sv
// Shared types for the LCD hardware-cursor overlay: pixel type, cursor codes and shadow registers.
package lcd_crsr_pkg;

  localparam int CRSR_DIM = 32;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    PAL0   = 2'b00,
    PAL1   = 2'b01,
    TRANSP = 2'b10,
    INV    = 2'b11
  } crsr_code_e;

  typedef struct packed {
    logic        en;
    logic [1:0]  img;
    logic [10:0] x;
    logic [9:0]  y;
    logic [4:0]  clip_x;
    logic [4:0]  clip_y;
  } crsr_shadow_t;

  // Two-bit cursor code for column col of a 16-pixel word, leftmost pixel in the MSBs.
  function automatic crsr_code_e code_sel(input logic [31:0] word, input logic [3:0] col);
    logic [31:0] shifted;
    shifted = word << {col, 1'b0};
    return crsr_code_e'(shifted[31:30]);
  endfunction

endpackage

// File: rtl/lcd_crsr_pos_cnt.sv
// Panel position counters: x runs 0..ppl per accepted pixel, y runs 0..lpp per line; v_sync clears both.
module lcd_crsr_pos_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        adv,
  input  logic [10:0] ppl,
  input  logic [9:0]  lpp,
  output logic [10:0] x,
  output logic [9:0]  y
);

  // Wrap with >= so a mid-frame shrink of ppl/lpp cannot run the counters away.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x >= ppl) begin
        x <= '0;
        y <= (y >= lpp) ? '0 : y + 10'd1;
      end else begin
        x <= x + 11'd1;
      end
    end
  end

endmodule

// File: rtl/lcd_crsr_overlay.sv
// Two-stage hardware-cursor overlay between palette and timing controller.
// Define LCD_CRSR_INVERT_EN to make cursor code 11 invert the underlying pixel.
module lcd_crsr_overlay
  import lcd_crsr_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        v_sync,
  input  logic [23:0] pix_in,
  input  logic        pix_in_valid,
  output logic        pix_in_stall,
  output logic [23:0] pix_out,
  output logic        pix_out_valid,
  input  logic        pix_out_stall,
  input  logic [10:0] ppl,
  input  logic [9:0]  lpp,
  input  logic        crsr_en,
  input  logic [1:0]  crsr_img,
  input  logic [10:0] crsr_x,
  input  logic [9:0]  crsr_y,
  input  logic [4:0]  clip_x,
  input  logic [4:0]  clip_y,
  input  logic [23:0] crsr_pal0,
  input  logic [23:0] crsr_pal1,
  output logic [7:0]  crsr_raddr,
  input  logic [31:0] crsr_rdata
);

  crsr_shadow_t shadow;
  logic [10:0]  x_p0;
  logic [9:0]   y_p0;
  logic [11:0]  cx_p0, cy_p0;
  logic         hit_p0, accept_p0;
  logic [7:0]   raddr_p0;
  logic         stall_p1, stall_p2;
  logic         vld_p1, vld_p2;
  pixel_t       pix_p1, pix_res;
  logic         hit_p1;
  logic [3:0]   col_p1;
  logic [7:0]   raddr_p1;

  assign stall_p2     = vld_p2 & pix_out_stall;
  assign stall_p1     = vld_p1 & stall_p2;
  assign pix_in_stall = stall_p1 & ~v_sync;
  assign accept_p0    = pix_in_valid & ~stall_p1 & ~v_sync;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      shadow <= '0;
    end else if (v_sync) begin
      shadow <= '{en: crsr_en, img: crsr_img, x: crsr_x, y: crsr_y,
                  clip_x: clip_x, clip_y: clip_y};
    end
  end

  lcd_crsr_pos_cnt u_pos (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .clr   (v_sync),
    .adv   (accept_p0),
    .ppl   (ppl),
    .lpp   (lpp),
    .x     (x_p0),
    .y     (y_p0)
  );

  // ---- stage 0: hit test and cursor RAM address for the pixel being offered
  assign cx_p0    = {1'b0, x_p0} - {1'b0, shadow.x} + {7'd0, shadow.clip_x};
  assign cy_p0    = {2'b0, y_p0} - {2'b0, shadow.y} + {7'd0, shadow.clip_y};
  assign hit_p0   = shadow.en & (x_p0 >= shadow.x) & (y_p0 >= shadow.y) &
                    (cx_p0 <= 12'(CRSR_DIM - 1)) & (cy_p0 <= 12'(CRSR_DIM - 1));
  assign raddr_p0 = {shadow.img, cy_p0[4:0], cx_p0[4]};

  // The RAM is read one edge ahead, so stage 1's own address is replayed while it is held.
  assign crsr_raddr = stall_p1 ? raddr_p1 : raddr_p0;

  // ---- stage 1: registered position result and pixel
  always_ff @(posedge HCLK) begin
    if (!HRESETn || v_sync) begin
      vld_p1 <= 1'b0;
    end else if (!stall_p1) begin
      vld_p1 <= accept_p0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept_p0) begin
      pix_p1   <= pix_in;
      hit_p1   <= hit_p0;
      col_p1   <= cx_p0[3:0];
      raddr_p1 <= raddr_p0;
    end
  end

  always_comb begin
    pix_res = pix_p1;
    if (hit_p1) begin
      case (code_sel(crsr_rdata, col_p1))
        PAL0:   pix_res = crsr_pal0;
        PAL1:   pix_res = crsr_pal1;
        TRANSP: pix_res = pix_p1;
`ifdef LCD_CRSR_INVERT_EN
        INV:    pix_res = ~pix_p1;
`else
        INV:    pix_res = pix_p1;
`endif
      endcase
    end
  end

  // ---- stage 2: resolved output pixel
  always_ff @(posedge HCLK) begin
    if (!HRESETn || v_sync) begin
      vld_p2 <= 1'b0;
    end else if (!stall_p2) begin
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pix_out <= '0;
    end else if (!stall_p2 && vld_p1) begin
      pix_out <= pix_res;
    end
  end

  assign pix_out_valid = vld_p2;

endmodule

// File: tb/tb_lcd_crsr_overlay.sv
// Randomised and directed bench for lcd_crsr_overlay against a frame-index reference model.
module tb_lcd_crsr_overlay;

  logic        HCLK = 1'b0;
  logic        HRESETn, v_sync, pix_in_valid, pix_in_stall, pix_out_valid, pix_out_stall;
  logic [23:0] pix_in, pix_out, crsr_pal0, crsr_pal1;
  logic [10:0] ppl, crsr_x;
  logic [9:0]  lpp, crsr_y;
  logic        crsr_en;
  logic [1:0]  crsr_img;
  logic [4:0]  clip_x, clip_y;
  logic [7:0]  crsr_raddr;
  logic [31:0] crsr_rdata;
  logic [31:0] mem [256];

  typedef struct { logic [23:0] pix; int cyc; } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0, cyc = 0, n = 0;
  bit s_en;
  int s_img, s_x, s_y, s_cx, s_cy;
  bit lat_chk, hold_pend, raddr_pend, rst_pend, vs_pend, last_acc, seq_mode;
  logic [23:0] hold_pix, cur_pix;
  logic [7:0]  prev_raddr;

  lcd_crsr_overlay dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .v_sync(v_sync),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_stall(pix_in_stall),
    .pix_out(pix_out), .pix_out_valid(pix_out_valid), .pix_out_stall(pix_out_stall),
    .ppl(ppl), .lpp(lpp), .crsr_en(crsr_en), .crsr_img(crsr_img),
    .crsr_x(crsr_x), .crsr_y(crsr_y), .clip_x(clip_x), .clip_y(clip_y),
    .crsr_pal0(crsr_pal0), .crsr_pal1(crsr_pal1),
    .crsr_raddr(crsr_raddr), .crsr_rdata(crsr_rdata)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) crsr_rdata <= mem[crsr_raddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] expect_pix(input int x, input int y, input logic [23:0] p);
    int cx, cy, code;
    logic [31:0] w;
    if (!s_en || x < s_x || y < s_y) return p;
    cx = x - s_x + s_cx;
    cy = y - s_y + s_cy;
    if (cx > 31 || cy > 31) return p;
    w = mem[8'(s_img * 64 + cy * 2 + cx / 16)];
    code = int'((w >> (30 - 2 * (cx % 16))) & 32'd3);
    case (code)
      0: return crsr_pal0;
      1: return crsr_pal1;
      3: begin
`ifdef LCD_CRSR_INVERT_EN
        return ~p;
`else
        return p;
`endif
      end
      default: return p;
    endcase
  endfunction

  task automatic step(input logic vs, input logic iv, input logic [23:0] px,
                      input logic os, input logic rn);
    exp_t e;
    int x, y;
    @(negedge HCLK);
    if (rst_pend) begin
      check("rst_pix_out", pix_out, 0);
      check("rst_out_valid", pix_out_valid, 0);
      check("rst_in_stall", pix_in_stall, 0);
      check("rst_raddr", crsr_raddr, 0);
    end
    if (vs_pend) check("flush_valid", pix_out_valid, 0);
    if (hold_pend) begin
      check("hold_valid", pix_out_valid, 1);
      check("hold_pix", pix_out, hold_pix);
    end
    v_sync = vs; pix_in_valid = iv; pix_in = px; pix_out_stall = os; HRESETn = rn;
    #1;
    last_acc = 0;
    rst_pend = !rn;
    vs_pend = vs && rn;
    if (!rn) begin
      q.delete(); n = 0;
      s_en = 0; s_img = 0; s_x = 0; s_y = 0; s_cx = 0; s_cy = 0;
      hold_pend = 0; raddr_pend = 0;
      cyc++;
      return;
    end
    check("in_stall", pix_in_stall, (!vs && q.size() == 2 && os));
    if (raddr_pend && pix_in_stall) check("raddr_hold", crsr_raddr, prev_raddr);
    raddr_pend = pix_in_stall;
    prev_raddr = crsr_raddr;
    if (pix_out_valid && !os) begin
      if (q.size() == 0) begin
        check("spurious_out", pix_out_valid, 0);
      end else begin
        e = q.pop_front();
        check("pix_out", pix_out, e.pix);
        if (lat_chk) check("latency", cyc - e.cyc, 2);
      end
    end
    hold_pend = pix_out_valid && os && !vs;
    hold_pix = pix_out;
    if (vs) begin
      q.delete(); n = 0;
      s_en = crsr_en; s_img = crsr_img; s_x = crsr_x; s_y = crsr_y;
      s_cx = clip_x; s_cy = clip_y;
    end else if (iv && !pix_in_stall) begin
      x = n % (int'(ppl) + 1);
      y = (n / (int'(ppl) + 1)) % (int'(lpp) + 1);
      e.pix = expect_pix(x, y, px);
      e.cyc = cyc;
      q.push_back(e);
      n++;
      last_acc = 1;
    end
    cyc++;
  endtask

  task automatic run(input int cycles, input int pv, input int ps);
    for (int i = 0; i < cycles; i++) begin
      step(1'b0, ($urandom_range(99) < pv), cur_pix, ($urandom_range(99) < ps), 1'b1);
      if (last_acc) cur_pix = seq_mode ? cur_pix + 24'd1 : 24'($urandom);
    end
  endtask

  task automatic frame();
    step(1'b1, 1'b1, cur_pix, 1'b0, 1'b1);
  endtask

  task automatic drain();
    run(6, 0, 0);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    crsr_pal0 = 24'hA5_5A_0F; crsr_pal1 = 24'h12_34_56;
    ppl = 11'd7; lpp = 10'd3;
    crsr_en = 0; crsr_img = 0; crsr_x = 0; crsr_y = 0; clip_x = 0; clip_y = 0;
    v_sync = 0; pix_in_valid = 0; pix_in = 0; pix_out_stall = 0; HRESETn = 0;
    cur_pix = 24'h000001; seq_mode = 1;

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Pass-through frame with wrap of both counters
    frame();
    cur_pix = 24'h000001;
    lat_chk = 1;
    run(32, 100, 0);
    run(4, 0, 0);
    lat_chk = 0;
    check("s1_count", cur_pix, 24'h000021);
    drain();

    // Cursor palette decode on line 1
    mem[0] = 32'h1B00_0000;
    crsr_en = 1; crsr_x = 2; crsr_y = 1;
    frame();
    seq_mode = 0;
    run(32, 100, 0);
    drain();

    // Downstream stall mid-line
    frame();
    run(12, 100, 0);
    run(5, 100, 100);
    run(20, 100, 0);
    drain();

    // Mid-frame position change only takes effect after v_sync
    ppl = 11'd15; lpp = 10'd1; crsr_x = 4; crsr_y = 0;
    frame();
    run(6, 100, 0);
    crsr_x = 10;
    run(26, 100, 0);
    frame();
    run(32, 100, 0);
    drain();

    // v_sync with both stages full and downstream stalled
    ppl = 11'd7; lpp = 10'd3; crsr_x = 0; crsr_y = 0;
    frame();
    run(4, 100, 100);
    step(1, 1, cur_pix, 1, 1);
    run(10, 100, 0);
    drain();

    // Clipped cursor at the right edge, then reset mid-line
    crsr_x = 6; clip_x = 30; clip_y = 0;
    frame();
    run(16, 100, 0);
    run(3, 100, 0);
    step(0, 0, 0, 1, 0);
    run(4, 100, 0);
    frame();
    run(8, 100, 0);
    drain();

    // Random stress
    for (int f = 0; f < 6; f++) begin
      ppl = 11'($urandom_range(12, 3)); lpp = 10'($urandom_range(4, 1));
      crsr_en = 1; crsr_img = 2'($urandom);
      crsr_x = 11'($urandom_range(int'(ppl))); crsr_y = 10'($urandom_range(int'(lpp)));
      clip_x = 5'($urandom); clip_y = 5'($urandom_range(31, 28));
      frame();
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(99) < 2) begin
          frame();
        end else begin
          run(1, 80, 30);
        end
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
